uart_tx_fifo: RTL



---
 rtl/uart_tx_fifo.sv | 139 +++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- transmit byte buffer placed directly upstream of uart_tx.
//
// The host writes bytes into a circular FIFO at up to one byte per clock.
// A two-state FSM hands one byte at a time to uart_tx using its
// data_avail / busy / done handshake. This lets the host burst up to DEPTH
// bytes without waiting for each UART frame to finish.
//
// Parameters:
//   DEPTH   FIFO entries (power of two, >= 2)
//   ADDR_W  pointer width, derived from DEPTH
//
// Ports:
//   i_clk       system clock
//   i_rst       synchronous reset, active-high
//   i_wr_en     host write strobe, one byte per cycle
//   i_wr_data   host write byte
//   o_full      count == DEPTH (registered)
//   o_empty     count == 0 (registered)
//   o_count     bytes stored, not counting the byte currently in flight
//   o_tx_byte   to uart_tx i_data_byte; held stable until the next issue
//   o_tx_start  to uart_tx i_data_avail; one-cycle pulse
//   i_tx_busy   from uart_tx o_busy
//   i_tx_done   from uart_tx o_done
//
// Optional build macro UART_TX_FIFO_OVERFLOW_EN adds:
//   i_ovf_clr   clears the sticky overflow flag
//   o_overflow  sticky flag, set when a write arrives while full
//               (a set on the same edge as a clear takes priority)
module uart_tx_fifo #(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [7:0]        i_wr_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic [7:0]        o_tx_byte,
  output logic              o_tx_start,
  input  logic              i_tx_busy,
  input  logic              i_tx_done
`ifdef UART_TX_FIFO_OVERFLOW_EN
  ,
  input  logic              i_ovf_clr,
  output logic              o_overflow
`endif
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    IDLE,
    WAIT_DONE
  } state_t;

  state_t              state;
  logic [7:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [ADDR_W:0]     count;
  logic [ADDR_W:0]     count_nxt;
  logic                wr_acc;
  logic                issue;

  // o_full is the registered flag, so a write on the edge that would
  // otherwise free a slot is still rejected.
  assign wr_acc  = i_wr_en && !o_full;
  assign issue   = (state == IDLE) && (count != '0) && !i_tx_busy;
  assign o_count = count;

  always_comb begin
    count_nxt = count;
    case ({wr_acc, issue})
      2'b10:   count_nxt = count + (ADDR_W + 1)'(1);
      2'b01:   count_nxt = count - (ADDR_W + 1)'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage holds data only; it is never reset.
  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_full     <= 1'b0;
      o_empty    <= 1'b1;
      o_tx_byte  <= 8'h00;
      o_tx_start <= 1'b0;
      state      <= IDLE;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      count      <= count_nxt;
      o_full     <= (count_nxt == FULL_COUNT);
      o_empty    <= (count_nxt == '0);
      o_tx_start <= 1'b0;
      case (state)
        IDLE: begin
          // A stray i_tx_done while idle is ignored.
          if (issue) begin
            o_tx_byte  <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + ADDR_W'(1);
            o_tx_start <= 1'b1;
            state      <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (i_tx_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVERFLOW_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_overflow <= 1'b0;
    end else if (i_wr_en && o_full) begin
      o_overflow <= 1'b1;
    end else if (i_ovf_clr) begin
      o_overflow <= 1'b0;
    end
  end
`endif

endmodule
